pc_sequencer: RTL
=================

// Module: pc_sequencer
// PURPOSE
//  Parametrised next-generation program-counter unit for the pipelined RSA CPU fetch stage.
//  Holds the PC and the NZCV flags register. Evaluates the branch condition.
//  Supports branch, branch-with-link and return through a return-address stack (RAS).
//  Adds start/stall/halt sequencing and a priority redirect from later pipeline stages.
// PARAMETERS
//  XLEN         32  PC / address width
//  IMM_W        24  branch immediate width (two's complement, sign-extended to XLEN)
//  IMM_SHIFT    0   left shift applied to sign-extended immediate before add
//  RESET_VECTOR 0   PC value after reset
//  RAS_DEPTH    4   return-address stack entries (power of 2, >=2)
// PORTS
//  clk          in   1      clock, rising edge
//  reset        in   1      asynchronous, active-low reset
//  start        in   1      leave IDLE, begin sequential fetch
//  stall        in   1      hold all state this cycle
//  redirect     in   1      load redirect_pc (flush/exception), highest priority
//  redirect_pc  in   XLEN   redirect target
//  halt_req     in   1      enter HALTED
//  FlagsWrite   in   1      write ALUFlags into flags register
//  ALUFlags     in   4      {N,Z,C,V} from ALU
//  Branch       in   2      branch_t: 00 NONE, 01 BL, 10 B, 11 RET
//  Cond         in   4      condition code (EQ..AL, ARM encoding; 1111 = never)
//  Imm          in   IMM_W  branch offset
//  pc           out  XLEN   current PC (registered)
//  pc_valid     out  1      1 in RUN and not stalled
//  link_we      out  1      1-cycle pulse on taken BL
//  link_addr    out  XLEN   pc+4 of the taken BL
//  halted       out  1      1 in HALTED
//  ras_empty    out  1      RAS holds no entries
//  ras_err      out  1      sticky: RAS overflow or underflow since reset
// BEHAVIOUR
//  Reset: pc=RESET_VECTOR, state=IDLE, flags=0, RAS empty, link_we=0, ras_err=0, pc_valid=0, halted=0.
//  FSM IDLE -> RUN on start. RUN -> HALTED on halt_req. HALTED -> RUN on redirect only. start ignored outside IDLE.
//  Per-cycle priority in RUN: redirect > stall > halt_req > taken branch > pc+4.
//  redirect in any state: pc<=redirect_pc. IDLE stays IDLE. HALTED->RUN. RAS and flags are kept.
//  stall: pc, state, RAS, flags, link unchanged. link_we=0. FlagsWrite is ignored.
//  Flags: updated on the clock edge when FlagsWrite & !stall.
//  Cond is evaluated against the registered flags. No bypass: same-cycle FlagsWrite does not affect this cycle's branch.
//  taken = (Branch!=NONE) & CondEx & state==RUN & !stall & !redirect & !halt_req.
//  B taken: pc <= pc + (sext(Imm) << IMM_SHIFT), modulo 2^XLEN (wraps silently).
//  BL taken: same target. Push pc+4. link_we=1, link_addr=pc+4 (combinational, same cycle).
//  RET taken, RAS non-empty: pc <= top entry, pop.
//  RET taken, RAS empty: pc <= pc+4, ras_err set.
//  RAS full + push: oldest entry overwritten (circular), ras_err set. Depth stays RAS_DEPTH.
//  Not taken (cond false or NONE): pc <= pc+4. No RAS change.
//  pc+4 wraps at 2^XLEN.
//  IDLE/HALTED: pc held; Branch ignored; FlagsWrite still honoured unless stall.
//  Reset asserted mid-operation: everything returns to reset values immediately (async).
// STRUCTURE
//  Package pc_seq_pkg: branch_t enum, cond_t codes, flags_t struct {n,z,c,v}, seq_state_t {IDLE,RUN,HALTED}.
//  Sub-module pc_cond_eval: comb Cond x flags -> CondEx.
//  RAS, FSM, flags register and PC register live inside pc_sequencer.
// TESTING
//  Reset, then start=1 for 1 cycle, 3 cycles free-run -> pc 0,4,8,12. pc_valid=1 from first RUN cycle.
//  Z flag set via FlagsWrite (ALUFlags=0100). Then B Cond=EQ Imm=0x000010 at pc=8 -> next pc=0x18.
//     Same with Cond=NE -> pc=0xC.
//  Same-cycle FlagsWrite=1 ALUFlags=0100 with B Cond=EQ while Z=0 -> not taken, pc+4.
//  BL at pc=0x20, Imm=0x40 -> link_we=1, link_addr=0x24, pc=0x60.
//     Later RET Cond=AL -> pc=0x24, ras_empty=1.
//  5 BLs with RAS_DEPTH=4 -> ras_err=1.
//     4 RETs return the last 4 link addresses (LIFO). 5th RET -> pc+4.
//  stall with Branch=B taken -> pc, flags unchanged.
//     redirect=1 with stall=1, redirect_pc=0x100 -> pc=0x100.
//     halt_req -> halted=1, pc frozen.
//     Async reset mid-run -> pc=RESET_VECTOR within same cycle.

Source files
------------

// File: rtl/pc_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pc_seq_pkg
//  Purpose  : Shared types for the fetch-stage program-counter sequencer:
//             branch kinds, ARM condition codes, NZCV flags, FSM states.
//  Revision : 1.0  initial release
// ============================================================================
package pc_seq_pkg;

    typedef enum logic [1:0] {
        BR_NONE = 2'b00,
        BR_BL   = 2'b01,
        BR_B    = 2'b10,
        BR_RET  = 2'b11
    } branch_t;

    typedef enum logic [3:0] {
        COND_EQ = 4'b0000,
        COND_NE = 4'b0001,
        COND_CS = 4'b0010,
        COND_CC = 4'b0011,
        COND_MI = 4'b0100,
        COND_PL = 4'b0101,
        COND_VS = 4'b0110,
        COND_VC = 4'b0111,
        COND_HI = 4'b1000,
        COND_LS = 4'b1001,
        COND_GE = 4'b1010,
        COND_LT = 4'b1011,
        COND_GT = 4'b1100,
        COND_LE = 4'b1101,
        COND_AL = 4'b1110,
        COND_NV = 4'b1111
    } cond_t;

    // Bit order matches the ALU flag bus {N,Z,C,V}
    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } flags_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_RUN    = 2'b01,
        ST_HALTED = 2'b10
    } seq_state_t;

endpackage : pc_seq_pkg
`default_nettype wire

// File: rtl/pc_cond_eval.sv
`default_nettype none
// ============================================================================
//  Module   : pc_cond_eval
//  Purpose  : Combinational ARM condition-code check against NZCV flags.
//  Revision : 1.0  initial release
// ============================================================================
module pc_cond_eval
    import pc_seq_pkg::*;
(
    input  logic [3:0] cond,
    input  flags_t     flags,
    output logic       cond_ex
);

    // Decode the condition field; the all-ones encoding never executes
    always_comb begin
        cond_ex = 1'b0;
        case (cond_t'(cond))
            COND_EQ: cond_ex = flags.z;
            COND_NE: cond_ex = !flags.z;
            COND_CS: cond_ex = flags.c;
            COND_CC: cond_ex = !flags.c;
            COND_MI: cond_ex = flags.n;
            COND_PL: cond_ex = !flags.n;
            COND_VS: cond_ex = flags.v;
            COND_VC: cond_ex = !flags.v;
            COND_HI: cond_ex = flags.c && !flags.z;
            COND_LS: cond_ex = !flags.c || flags.z;
            COND_GE: cond_ex = (flags.n == flags.v);
            COND_LT: cond_ex = (flags.n != flags.v);
            COND_GT: cond_ex = !flags.z && (flags.n == flags.v);
            COND_LE: cond_ex = flags.z || (flags.n != flags.v);
            COND_AL: cond_ex = 1'b1;
            default: cond_ex = 1'b0;
        endcase
    end

endmodule : pc_cond_eval
`default_nettype wire

// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : pc_sequencer
//  Purpose  : Fetch-stage program counter with NZCV flags, conditional
//             branch / branch-with-link / return via a circular return-address
//             stack, start/stall/halt sequencing and priority redirect.
//  Revision : 1.0  initial release
// ============================================================================
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int               XLEN         = 32,
    parameter int               IMM_W        = 24,
    parameter int               IMM_SHIFT    = 0,
    parameter logic [XLEN-1:0]  RESET_VECTOR = '0,
    parameter int               RAS_DEPTH    = 4
)(
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              stall,
    input  logic              redirect,
    input  logic [XLEN-1:0]   redirect_pc,
    input  logic              halt_req,
    input  logic              FlagsWrite,
    input  logic [3:0]        ALUFlags,
    input  logic [1:0]        Branch,
    input  logic [3:0]        Cond,
    input  logic [IMM_W-1:0]  Imm,
    output logic [XLEN-1:0]   pc,
    output logic              pc_valid,
    output logic              link_we,
    output logic [XLEN-1:0]   link_addr,
    output logic              halted,
    output logic              ras_empty,
    output logic              ras_err
);

    localparam int PW = $clog2(RAS_DEPTH);
    localparam logic [PW-1:0] PTR_ONE = PW'(1);
    localparam logic [PW:0]   CNT_ONE = (PW+1)'(1);
    localparam logic [PW:0]   CNT_MAX = (PW+1)'(RAS_DEPTH);

    seq_state_t        state, state_nxt;
    logic [XLEN-1:0]   pc_nxt;
    flags_t            flags;
    branch_t           br;
    logic              cond_ex;
    logic              active;
    logic              taken;
    logic              push;
    logic              pop_req;
    logic              pop;
    logic              ras_full;
    logic [XLEN-1:0]   pc_plus4;
    logic [XLEN-1:0]   imm_ext;
    logic [XLEN-1:0]   br_target;
    logic [XLEN-1:0]   ras_mem [RAS_DEPTH];
    logic [PW-1:0]     ras_wp;
    logic [PW-1:0]     ras_rp;
    logic [PW:0]       ras_cnt;

    pc_cond_eval u_cond (
        .cond    (Cond),
        .flags   (flags),
        .cond_ex (cond_ex)
    );

    // Branch decision and datapath helpers; flags are the registered copy only
    always_comb begin
        br        = branch_t'(Branch);
        active    = (state == ST_RUN) && !stall && !redirect && !halt_req;
        taken     = active && (br != BR_NONE) && cond_ex;
        push      = taken && (br == BR_BL);
        pop_req   = taken && (br == BR_RET);
        pop       = pop_req && !ras_empty;
        pc_plus4  = pc + XLEN'(4);
        imm_ext   = XLEN'($signed(Imm));
        br_target = pc + (imm_ext << IMM_SHIFT);
        ras_rp    = ras_wp - PTR_ONE;
        ras_full  = (ras_cnt == CNT_MAX);
        ras_empty = (ras_cnt == '0);
        link_we   = push;
        link_addr = pc_plus4;
        pc_valid  = (state == ST_RUN) && !stall;
        halted    = (state == ST_HALTED);
    end

    // Next state / next PC: redirect > stall > halt_req > taken branch > pc+4
    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        if (redirect) begin
            pc_nxt = redirect_pc;
            if (state == ST_HALTED) begin
                state_nxt = ST_RUN;
            end
        end else if (!stall) begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state_nxt = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (halt_req) begin
                        state_nxt = ST_HALTED;
                    end else if (taken && (br != BR_RET)) begin
                        pc_nxt = br_target;
                    end else if (pop) begin
                        pc_nxt = ras_mem[ras_rp];
                    end else begin
                        pc_nxt = pc_plus4;
                    end
                end
                ST_HALTED: begin
                    state_nxt = ST_HALTED;
                end
                default: begin
                    state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    // PC and FSM state registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
            pc    <= RESET_VECTOR;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
        end
    end

    // Flags register: written in any state unless stalled
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            flags <= '0;
        end else if (FlagsWrite && !stall) begin
            flags <= flags_t'(ALUFlags);
        end
    end

    // RAS pointers: a push onto a full stack overwrites the oldest entry
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ras_wp  <= '0;
            ras_cnt <= '0;
            ras_err <= 1'b0;
        end else begin
            if (push) begin
                ras_wp <= ras_wp + PTR_ONE;
                if (!ras_full) begin
                    ras_cnt <= ras_cnt + CNT_ONE;
                end else begin
                    ras_err <= 1'b1;
                end
            end else if (pop) begin
                ras_wp  <= ras_rp;
                ras_cnt <= ras_cnt - CNT_ONE;
            end else if (pop_req) begin
                ras_err <= 1'b1;
            end
        end
    end

    // RAS storage: contents are only meaningful under the count, so no reset
    always_ff @(posedge clk) begin
        if (push) begin
            ras_mem[ras_wp] <= pc_plus4;
        end
    end

endmodule : pc_sequencer
`default_nettype wire
